dmi_axil_master: RTL and testbench
==================================

DMI_AXIL_MASTER -- requirements
Module: dmi_axil_master

Interface
REQ-001 SHALL have parameter AddrWidth, default 18, AXI-Lite byte-address width.
REQ-002 SHALL have parameter DataWidth, default 32, AXI-Lite and DMI data width.
REQ-003 SHALL have parameter DmiAddrWidth, default 17, DMI word-address width.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous reset, active high.
REQ-005 SHALL have these DMI request ports: dmi_req_valid_i  in  1  request valid; dmi_req_ready_o  out  1  request accepted; dmi_req_addr_i  in  DmiAddrWidth  word address; dmi_req_data_i  in  DataWidth  write data; dmi_req_op_i  in  2  0 nop, 1 read, 2 write, 3 reserved.
REQ-006 SHALL have these DMI response ports: dmi_resp_valid_o  out  1  response valid; dmi_resp_ready_i  in  1  response taken; dmi_resp_data_o  out  DataWidth  read data; dmi_resp_resp_o  out  2  0 ok, 2 failed.
REQ-007 SHALL have these AXI-Lite master ports: axilite  master modport  AXI_LITE, AddrWidth/DataWidth.

Function
REQ-008 SHALL implement FSM states IDLE, WRITE, WRITE_RESP, READ_ADDR, READ_DATA, RESP.
REQ-009 SHALL drive dmi_req_ready_o high only in IDLE; a request is accepted on the cycle dmi_req_valid_i and dmi_req_ready_o are both high.
REQ-010 SHALL capture addr/data/op in registers on acceptance; later changes to request inputs have no effect.
REQ-011 SHALL form the AXI address as {dmi_req_addr_i, 2'b00}, truncated to AddrWidth LSBs.
REQ-012 On write acceptance: go to WRITE; assert aw_valid and w_valid from the next cycle; w_strb all ones; aw_prot 0.
REQ-013 In WRITE: drop aw_valid after the AW handshake and w_valid after the W handshake, independently; go to WRITE_RESP once both handshakes are done, including when both occur in the same cycle.
REQ-014 In WRITE_RESP: hold b_ready high; on the B handshake, go to RESP with resp 0 for OKAY/EXOKAY and 2 for SLVERR/DECERR.
REQ-015 On read acceptance: go to READ_ADDR; hold ar_valid high with ar_prot 0 until the AR handshake, then go to READ_DATA.
REQ-016 In READ_DATA: hold r_ready high; on the R handshake, capture r_data into the response data and map r_resp as in REQ-014.
REQ-017 On nop acceptance: go directly to RESP with data 0 and resp 0; issue no AXI traffic.
REQ-018 On op 3 acceptance: go directly to RESP with data 0 and resp 2; issue no AXI traffic.
REQ-019 In RESP: assert dmi_resp_valid_o and hold data/resp stable until dmi_resp_ready_i; on that handshake, return to IDLE.
REQ-020 After a write, dmi_resp_data_o SHALL be 0.
REQ-021 Each AXI valid, once asserted, SHALL stay high with stable payload until its handshake.
REQ-022 At most one transaction SHALL be outstanding.
REQ-023 Best-case latency, request acceptance to dmi_resp_valid_o: write 3 cycles; read 3 cycles; nop 1 cycle.

Reset
REQ-024 On rst_i: state IDLE; all AXI valids/readies 0; dmi_resp_valid_o 0; response data 0; response resp 0; dmi_req_ready_o 1 from the first cycle after reset.
REQ-025 Reset mid-transaction SHALL abandon the transaction with no DMI response; the system resets the AXI slave together with this block.

Structure
REQ-026 The op and resp encodings and the state enum SHALL be defined in a shared package dmi_axil_pkg.
REQ-027 The block SHALL be a single module with no sub-modules; the DTM instantiates it between the DMI register and the AXI-Lite port.

Verification
REQ-028 The bench SHALL check: write op 2, addr 0x3, data 0xfaceb00c -> aw_addr 0x0000C, w_data 0xfaceb00c, w_strb 0xF, then resp 0 and data 0.
REQ-029 The bench SHALL check: after the REQ-028 write, read op 1, addr 0x3 -> ar_addr 0x0000C, then dmi_resp_data_o 0xfaceb00c with resp 0.
REQ-030 The bench SHALL check: write with aw_ready delayed 5 cycles and w_ready immediate -> exactly one AW and one W handshake, with b_ready asserted only afterwards.
REQ-031 The bench SHALL check: slave returns SLVERR on a read -> resp 2, and the next request is accepted normally.
REQ-032 The bench SHALL check: nop and op 3 -> response after 1 cycle with resp 0 and resp 2 respectively, and no AXI valid asserted.
REQ-033 The bench SHALL check: dmi_resp_ready_i held low for 10 cycles -> response data stable and dmi_req_ready_o low throughout; rst_i asserted in READ_DATA -> all valids 0 the following cycle.

Source files
------------

// File: rtl/dmi_axil_pkg.sv
// Shared encodings for the DMI-to-AXI-Lite bridge: DMI op/resp codes, AXI
// response codes, controller state enum and the AXI->DMI response mapping.
package dmi_axil_pkg;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2,
        DMI_OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_RESP_OK     = 2'd0,
        DMI_RESP_RSVD   = 2'd1,
        DMI_RESP_FAILED = 2'd2,
        DMI_RESP_BUSY   = 2'd3
    } dmi_resp_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        WRITE_RESP = 3'd2,
        READ_ADDR  = 3'd3,
        READ_DATA  = 3'd4,
        RESP       = 3'd5
    } state_e;

    // Any AXI error (SLVERR/DECERR) collapses to a failed DMI op.
    function automatic dmi_resp_e axi_to_dmi_resp(input logic [1:0] axi_resp);
        dmi_resp_e r;
        case (axi_resp)
            AXI_RESP_OKAY, AXI_RESP_EXOKAY: r = DMI_RESP_OK;
            default:                        r = DMI_RESP_FAILED;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/AXI_LITE.sv
// AXI-Lite bus bundle.
//   master modport: drives AW/W/AR channels and B/R readies.
//   slave  modport: mirror image.
interface AXI_LITE #(
    parameter int unsigned AddrWidth = 18,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic [AddrWidth-1:0] aw_addr;
    logic [2:0]           aw_prot;
    logic                 aw_valid;
    logic                 aw_ready;
    logic [DataWidth-1:0] w_data;
    logic [StrbWidth-1:0] w_strb;
    logic                 w_valid;
    logic                 w_ready;
    logic [1:0]           b_resp;
    logic                 b_valid;
    logic                 b_ready;
    logic [AddrWidth-1:0] ar_addr;
    logic [2:0]           ar_prot;
    logic                 ar_valid;
    logic                 ar_ready;
    logic [DataWidth-1:0] r_data;
    logic [1:0]           r_resp;
    logic                 r_valid;
    logic                 r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input r_data, r_resp, r_valid, output r_ready
    );

    modport slave (
        input aw_addr, aw_prot, aw_valid, output aw_ready,
        input w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );
endinterface

// File: rtl/dmi_axil_master.sv
// DMI-to-AXI-Lite bridge: turns one DMI request at a time into a single
// AXI-Lite read or write and returns a DMI response.
//   clk_i/rst_i      : clock, synchronous active-high reset
//   dmi_req_*        : DMI request (valid/ready, word addr, data, op)
//   dmi_resp_*       : DMI response (valid/ready, read data, status)
//   axilite          : AXI-Lite master port
module dmi_axil_master
    import dmi_axil_pkg::*;
#(
    parameter int unsigned AddrWidth    = 18,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned DmiAddrWidth = 17
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    dmi_req_valid_i,
    output logic                    dmi_req_ready_o,
    input  logic [DmiAddrWidth-1:0] dmi_req_addr_i,
    input  logic [DataWidth-1:0]    dmi_req_data_i,
    input  logic [1:0]              dmi_req_op_i,
    output logic                    dmi_resp_valid_o,
    input  logic                    dmi_resp_ready_i,
    output logic [DataWidth-1:0]    dmi_resp_data_o,
    output logic [1:0]              dmi_resp_resp_o,
    AXI_LITE.master                 axilite
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 aw_valid_q, aw_valid_d;
    logic                 w_valid_q, w_valid_d;
    logic                 ar_valid_q, ar_valid_d;
    logic                 b_ready_q, b_ready_d;
    logic                 r_ready_q, r_ready_d;
    logic                 req_ready_q, req_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [DataWidth-1:0] resp_data_q, resp_data_d;
    dmi_resp_e            resp_resp_q, resp_resp_d;

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            ar_valid_q   <= 1'b0;
            b_ready_q    <= 1'b0;
            r_ready_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_resp_q  <= DMI_RESP_OK;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            ar_valid_q   <= ar_valid_d;
            b_ready_q    <= b_ready_d;
            r_ready_q    <= r_ready_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_resp_q  <= resp_resp_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        ar_valid_d   = ar_valid_q;
        b_ready_d    = b_ready_q;
        r_ready_d    = r_ready_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_resp_d  = resp_resp_q;

        case (state_q)
            IDLE: begin
                if (dmi_req_valid_i && req_ready_q) begin
                    addr_d  = AddrWidth'({dmi_req_addr_i, 2'b00});
                    wdata_d = dmi_req_data_i;
                    unique case (dmi_op_e'(dmi_req_op_i))
                        DMI_OP_WRITE: begin
                            state_d    = WRITE;
                            aw_valid_d = 1'b1;
                            w_valid_d  = 1'b1;
                        end
                        DMI_OP_READ: begin
                            state_d    = READ_ADDR;
                            ar_valid_d = 1'b1;
                        end
                        DMI_OP_NOP: begin
                            state_d      = RESP;
                            resp_valid_d = 1'b1;
                            resp_data_d  = '0;
                            resp_resp_d  = DMI_RESP_OK;
                        end
                        DMI_OP_RSVD: begin
                            state_d      = RESP;
                            resp_valid_d = 1'b1;
                            resp_data_d  = '0;
                            resp_resp_d  = DMI_RESP_FAILED;
                        end
                    endcase
                end
            end
            WRITE: begin
                // AW and W retire independently; move on once neither is pending.
                aw_valid_d = aw_valid_q && !axilite.aw_ready;
                w_valid_d  = w_valid_q && !axilite.w_ready;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d   = WRITE_RESP;
                    b_ready_d = 1'b1;
                end
            end
            WRITE_RESP: begin
                if (axilite.b_valid) begin
                    state_d      = RESP;
                    b_ready_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                    resp_resp_d  = axi_to_dmi_resp(axilite.b_resp);
                end
            end
            READ_ADDR: begin
                if (axilite.ar_ready) begin
                    state_d    = READ_DATA;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            READ_DATA: begin
                if (axilite.r_valid) begin
                    state_d      = RESP;
                    r_ready_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = axilite.r_data;
                    resp_resp_d  = axi_to_dmi_resp(axilite.r_resp);
                end
            end
            RESP: begin
                if (dmi_resp_ready_i) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    assign dmi_req_ready_o  = req_ready_q;
    assign dmi_resp_valid_o = resp_valid_q;
    assign dmi_resp_data_o  = resp_data_q;
    assign dmi_resp_resp_o  = resp_resp_q;

    assign axilite.aw_addr  = addr_q;
    assign axilite.aw_prot  = 3'b000;
    assign axilite.aw_valid = aw_valid_q;
    assign axilite.w_data   = wdata_q;
    assign axilite.w_strb   = {StrbWidth{1'b1}};
    assign axilite.w_valid  = w_valid_q;
    assign axilite.b_ready  = b_ready_q;
    assign axilite.ar_addr  = addr_q;
    assign axilite.ar_prot  = 3'b000;
    assign axilite.ar_valid = ar_valid_q;
    assign axilite.r_ready  = r_ready_q;

endmodule

// File: tb/tb_dmi_axil_master.sv
// Directed bench for dmi_axil_master with a small AXI-Lite slave model.
module tb_dmi_axil_master;

    localparam int unsigned AW  = 18;
    localparam int unsigned DW  = 32;
    localparam int unsigned DAW = 17;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [DAW-1:0] req_addr;
    logic [DW-1:0]  req_data;
    logic [1:0]     req_op;
    logic           resp_valid;
    logic           resp_ready;
    logic [DW-1:0]  resp_data;
    logic [1:0]     resp_resp;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    AXI_LITE #(.AddrWidth(AW), .DataWidth(DW)) axil ();

    dmi_axil_master #(.AddrWidth(AW), .DataWidth(DW), .DmiAddrWidth(DAW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .dmi_req_valid_i  (req_valid),
        .dmi_req_ready_o  (req_ready),
        .dmi_req_addr_i   (req_addr),
        .dmi_req_data_i   (req_data),
        .dmi_req_op_i     (req_op),
        .dmi_resp_valid_o (resp_valid),
        .dmi_resp_ready_i (resp_ready),
        .dmi_resp_data_o  (resp_data),
        .dmi_resp_resp_o  (resp_resp),
        .axilite          (axil)
    );

    // ---------------- AXI-Lite slave model ----------------
    int         aw_delay   = 0;
    int         r_delay    = 0;
    logic [1:0] b_resp_cfg = 2'b00;
    logic [1:0] r_resp_cfg = 2'b00;

    logic [31:0] mem [0:15];
    int          aw_cnt;
    logic        aw_done, w_done, r_pend;
    int          r_cnt;
    logic [AW-1:0] aw_addr_q, r_addr_q;
    logic [DW-1:0] w_data_q;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [AW-1:0] aw_addr_c;
    logic [DW-1:0] w_data_c;

    assign aw_hs = axil.aw_valid && axil.aw_ready;
    assign w_hs  = axil.w_valid && axil.w_ready;
    assign ar_hs = axil.ar_valid && axil.ar_ready;
    assign b_hs  = axil.b_valid && axil.b_ready;
    assign r_hs  = axil.r_valid && axil.r_ready;
    assign aw_addr_c = aw_hs ? axil.aw_addr : aw_addr_q;
    assign w_data_c  = w_hs ? axil.w_data : w_data_q;

    assign axil.aw_ready = axil.aw_valid && (aw_cnt >= aw_delay);
    assign axil.w_ready  = axil.w_valid;
    assign axil.ar_ready = axil.ar_valid;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt       <= 0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            r_pend       <= 1'b0;
            r_cnt        <= 0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            r_addr_q     <= '0;
            axil.b_valid <= 1'b0;
            axil.b_resp  <= 2'b00;
            axil.r_valid <= 1'b0;
            axil.r_data  <= '0;
            axil.r_resp  <= 2'b00;
        end else begin
            if (aw_hs) aw_cnt <= 0;
            else if (axil.aw_valid) aw_cnt <= aw_cnt + 1;
            if (aw_hs) begin aw_done <= 1'b1; aw_addr_q <= axil.aw_addr; end
            if (w_hs)  begin w_done  <= 1'b1; w_data_q  <= axil.w_data;  end
            if (!axil.b_valid && (aw_done || aw_hs) && (w_done || w_hs)) begin
                axil.b_valid <= 1'b1;
                axil.b_resp  <= b_resp_cfg;
                mem[aw_addr_c[5:2]] <= w_data_c;
            end
            if (b_hs) begin
                axil.b_valid <= 1'b0;
                aw_done      <= 1'b0;
                w_done       <= 1'b0;
            end
            if (ar_hs) begin
                if (r_delay == 0) begin
                    axil.r_valid <= 1'b1;
                    axil.r_data  <= mem[axil.ar_addr[5:2]];
                    axil.r_resp  <= r_resp_cfg;
                end else begin
                    r_pend   <= 1'b1;
                    r_cnt    <= 1;
                    r_addr_q <= axil.ar_addr;
                end
            end
            if (r_pend) begin
                if (r_cnt >= r_delay) begin
                    axil.r_valid <= 1'b1;
                    axil.r_data  <= mem[r_addr_q[5:2]];
                    axil.r_resp  <= r_resp_cfg;
                    r_pend       <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
            if (r_hs) axil.r_valid <= 1'b0;
        end
    end

    // ---------------- bus monitor ----------------
    int            aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0;
    int            valid_cycles = 0, viol_cnt = 0;
    logic          bready_early = 1'b0;
    logic [AW-1:0] last_aw_addr = '0, last_ar_addr = '0;
    logic [DW-1:0] last_w_data = '0;
    logic [3:0]    last_w_strb = '0;
    logic          aw_pend_p = 1'b0, w_pend_p = 1'b0, ar_pend_p = 1'b0;
    logic [AW-1:0] aw_addr_p = '0, ar_addr_p = '0;
    logic [DW-1:0] w_data_p = '0;

    always @(posedge clk) begin
        if (aw_hs) begin aw_hs_cnt <= aw_hs_cnt + 1; last_aw_addr <= axil.aw_addr; end
        if (w_hs)  begin w_hs_cnt <= w_hs_cnt + 1; last_w_data <= axil.w_data; last_w_strb <= axil.w_strb; end
        if (ar_hs) begin ar_hs_cnt <= ar_hs_cnt + 1; last_ar_addr <= axil.ar_addr; end
        if (axil.aw_valid || axil.w_valid || axil.ar_valid) valid_cycles <= valid_cycles + 1;
        if (!rst && axil.b_ready && !(aw_done && w_done)) bready_early <= 1'b1;
        if (!rst) begin
            if (aw_pend_p && (!axil.aw_valid || axil.aw_addr != aw_addr_p)) viol_cnt <= viol_cnt + 1;
            else if (w_pend_p && (!axil.w_valid || axil.w_data != w_data_p)) viol_cnt <= viol_cnt + 1;
            else if (ar_pend_p && (!axil.ar_valid || axil.ar_addr != ar_addr_p)) viol_cnt <= viol_cnt + 1;
        end
        aw_pend_p <= !rst && axil.aw_valid && !axil.aw_ready;
        w_pend_p  <= !rst && axil.w_valid && !axil.w_ready;
        ar_pend_p <= !rst && axil.ar_valid && !axil.ar_ready;
        aw_addr_p <= axil.aw_addr;
        w_data_p  <= axil.w_data;
        ar_addr_p <= axil.ar_addr;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request; returns cycles from acceptance edge to resp_valid (-1 on timeout).
    task automatic issue(input logic [1:0] op, input logic [DAW-1:0] a,
                         input logic [DW-1:0] d, output int lat);
        int guard;
        @(negedge clk);
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) begin
                // Scribble the request inputs; the captured copy must be used.
                req_valid = 1'b0;
                req_addr  = '1;
                req_data  = 32'hdeadbeef;
                req_op    = 2'd2;
            end
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic take(input string tag);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_resp_dropped"}, 32'(resp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int n_aw, n_w, n_ar, n_v, bad;
        logic [DW-1:0] held_data;
        logic [1:0]    held_resp;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        req_op     = 2'd0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_axi_ctl", 32'({axil.aw_valid, axil.w_valid, axil.ar_valid,
                                   axil.b_ready, axil.r_ready}), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_resp", 32'(resp_resp), 32'd0);

        // Write 0xfaceb00c to word 3
        n_aw = aw_hs_cnt; n_w = w_hs_cnt;
        issue(2'd2, 17'h3, 32'hfaceb00c, lat);
        check("wr_latency", 32'(lat), 32'd3);
        check("wr_aw_addr", 32'(last_aw_addr), 32'h0000c);
        check("wr_w_data", last_w_data, 32'hfaceb00c);
        check("wr_w_strb", 32'(last_w_strb), 32'hf);
        check("wr_aw_count", 32'(aw_hs_cnt - n_aw), 32'd1);
        check("wr_w_count", 32'(w_hs_cnt - n_w), 32'd1);
        check("wr_resp", 32'(resp_resp), 32'd0);
        check("wr_data", resp_data, 32'd0);
        take("wr");

        // Read back word 3
        n_ar = ar_hs_cnt;
        issue(2'd1, 17'h3, 32'h0, lat);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_ar_addr", 32'(last_ar_addr), 32'h0000c);
        check("rd_ar_count", 32'(ar_hs_cnt - n_ar), 32'd1);
        check("rd_data", resp_data, 32'hfaceb00c);
        check("rd_resp", 32'(resp_resp), 32'd0);
        take("rd");

        // Write with AW ready held off 5 cycles, W ready immediately
        aw_delay = 5;
        n_aw = aw_hs_cnt; n_w = w_hs_cnt;
        issue(2'd2, 17'h5, 32'h12345678, lat);
        check("slow_aw_count", 32'(aw_hs_cnt - n_aw), 32'd1);
        check("slow_w_count", 32'(w_hs_cnt - n_w), 32'd1);
        check("slow_aw_addr", 32'(last_aw_addr), 32'h00014);
        check("slow_bready_early", 32'(bready_early), 32'd0);
        check("slow_resp", 32'(resp_resp), 32'd0);
        take("slow");
        aw_delay = 0;

        // DECERR on write -> failed; EXOKAY -> ok
        b_resp_cfg = 2'b11;
        issue(2'd2, 17'h6, 32'h0badf00d, lat);
        check("wr_decerr_resp", 32'(resp_resp), 32'd2);
        take("decerr");
        b_resp_cfg = 2'b01;
        issue(2'd2, 17'h7, 32'h00c0ffee, lat);
        check("wr_exokay_resp", 32'(resp_resp), 32'd0);
        take("exokay");
        b_resp_cfg = 2'b00;

        // SLVERR on read -> failed, then a normal read follows
        r_resp_cfg = 2'b10;
        issue(2'd1, 17'h3, 32'h0, lat);
        check("rd_slverr_resp", 32'(resp_resp), 32'd2);
        take("slverr");
        r_resp_cfg = 2'b00;
        issue(2'd1, 17'h5, 32'h0, lat);
        check("rd_after_err_latency", 32'(lat), 32'd3);
        check("rd_after_err_data", resp_data, 32'h12345678);
        check("rd_after_err_resp", 32'(resp_resp), 32'd0);
        take("after_err");

        // nop and reserved op: 1-cycle response, no AXI traffic
        n_v = valid_cycles;
        issue(2'd0, 17'h3, 32'h55aa55aa, lat);
        check("nop_latency", 32'(lat), 32'd1);
        check("nop_resp", 32'(resp_resp), 32'd0);
        check("nop_data", resp_data, 32'd0);
        take("nop");
        issue(2'd3, 17'h3, 32'h55aa55aa, lat);
        check("rsvd_latency", 32'(lat), 32'd1);
        check("rsvd_resp", 32'(resp_resp), 32'd2);
        check("rsvd_data", resp_data, 32'd0);
        take("rsvd");
        check("nop_rsvd_no_axi", 32'(valid_cycles - n_v), 32'd0);

        // Response held un-taken for 10 cycles
        issue(2'd1, 17'h3, 32'h0, lat);
        held_data = resp_data;
        held_resp = resp_resp;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_data !== held_data || resp_resp !== held_resp || req_ready)
                bad++;
        end
        check("hold_data", held_data, 32'hfaceb00c);
        check("hold_stable", 32'(bad), 32'd0);
        take("hold");

        // Reset while in READ_DATA abandons the transaction
        r_delay = 20;
        @(negedge clk);
        req_op    = 2'd1;
        req_addr  = 17'h3;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_ar_valid", 32'(axil.ar_valid), 32'd1);
        @(negedge clk);
        check("abort_in_read_data", 32'(axil.r_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_axi_ctl", 32'({axil.aw_valid, axil.w_valid, axil.ar_valid,
                                     axil.b_ready, axil.r_ready}), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        r_delay = 0;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (resp_valid) bad++;
        end
        check("abort_no_resp", 32'(bad), 32'd0);
        issue(2'd0, 17'h0, 32'h0, lat);
        check("post_abort_nop_latency", 32'(lat), 32'd1);
        take("post_abort");

        check("axi_valid_stability", 32'(viol_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
